// File: rtl/quadrature_decoder_pkg.sv
// Shared constants for the quadrature decoder slice.
// State codes follow the encoder's up sequence 00-10-11-01.
package quad_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q10 = 2'b10;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q01 = 2'b01;

  function automatic logic [1:0] qd_next_up(
    input logic [1:0] s
  );
    logic [1:0] n;
    unique case (s)
      Q00:     n = Q10;
      Q10:     n = Q11;
      Q11:     n = Q01;
      default: n = Q00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Pin-side and decoded-side signals of the quadrature decoder.
// master drives the encoder pins; slave is the decoder.
interface quadrature_decoder_if #(
  parameter int POS_WIDTH = 4
);

  logic                 enc_a;
  logic                 enc_b;
  logic                 step;
  logic                 dir;
  logic [POS_WIDTH-1:0] position;
  logic                 err;

  modport master (
    output enc_a, enc_b,
    input  step, dir, position, err
  );

  modport slave (
    input  enc_a, enc_b,
    output step, dir, position, err
  );

endinterface

// File: rtl/quadrature_decoder_debounce_filter.sv
// Two-flop synchroniser plus stability counter for one encoder pin.
// level takes a value only after it held DEBOUNCE_CYCLES samples.
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic valid
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          cand;
  logic [1:0]    fill;
  logic [CW-1:0] cnt;

  // fill keeps the reset zeros of the synchroniser out of the count
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cand    <= 1'b0;
      fill    <= 2'b00;
      cnt     <= '0;
      level   <= 1'b0;
      valid   <= 1'b0;
    end else begin
      sync_q1 <= pin;
      sync_q2 <= sync_q1;
      fill    <= {fill[0], 1'b1};
      if (!fill[1]) begin
        cnt <= '0;
      end else if (sync_q2 != cand) begin
        cand <= sync_q2;
        cnt  <= CW'(1);
      end else if (cnt == CNT_MAX) begin
        level <= cand;
        valid <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: debounced A/B channels to step, dir,
// a wrapping position count and an illegal-transition pulse.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int POS_WIDTH       = 4
) (
  input logic                 clk,
  input logic                 rst,
  quadrature_decoder_if.slave bus
);

  logic a_lvl, a_vld;
  logic b_lvl, b_vld;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_a (
    .clk  (clk),
    .rst  (rst),
    .pin  (bus.enc_a),
    .level(a_lvl),
    .valid(a_vld)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_b (
    .clk  (clk),
    .rst  (rst),
    .pin  (bus.enc_b),
    .level(b_lvl),
    .valid(b_vld)
  );

  logic [1:0]           ab;
  logic [1:0]           st_q, st_d;
  logic                 primed_q, primed_d;
  logic                 step_q, step_d;
  logic                 err_q, err_d;
  logic                 dir_q, dir_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;

  assign ab = {a_lvl, b_lvl};

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= Q00;
      primed_q <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      dir_q    <= DIR_UP;
      pos_q    <= '0;
    end else begin
      st_q     <= st_d;
      primed_q <= primed_d;
      step_q   <= step_d;
      err_q    <= err_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
    end
  end

  // first valid sample only loads the state, so idle pins never pulse
  always_comb begin
    st_d     = st_q;
    primed_d = primed_q;
    step_d   = 1'b0;
    err_d    = 1'b0;
    dir_d    = dir_q;
    pos_d    = pos_q;
    if (!primed_q) begin
      if (a_vld && b_vld) begin
        primed_d = 1'b1;
        st_d     = ab;
      end
    end else if (ab != st_q) begin
      st_d = ab;
      unique case (1'b1)
        (ab == qd_next_up(st_q)): begin
          step_d = 1'b1;
          dir_d  = DIR_UP;
          pos_d  = pos_q + POS_WIDTH'(1);
        end
        (st_q == qd_next_up(ab)): begin
          step_d = 1'b1;
          dir_d  = DIR_DOWN;
          pos_d  = pos_q - POS_WIDTH'(1);
        end
        default: begin
          err_d = 1'b1;
        end
      endcase
    end
  end

  assign bus.step     = step_q;
  assign bus.err      = err_q;
  assign bus.dir      = dir_q;
  assign bus.position = pos_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder with DEBOUNCE_CYCLES=4, POS_WIDTH=4.
// A pin-history model predicts every output cycle by cycle.
module tb_quadrature_decoder;

  localparam int D  = 4;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  quadrature_decoder_if #(.POS_WIDTH(PW)) bus ();

  quadrature_decoder #(
    .DEBOUNCE_CYCLES(D),
    .POS_WIDTH      (PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: position of a code in the up sequence 00,10,11,01
  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  logic [1:0]    m_hist[$];
  logic [1:0]    m_filt;
  logic          m_av, m_bv;
  logic          m_primed;
  logic [1:0]    m_st;
  logic          m_step, m_err, m_dir;
  logic [PW-1:0] m_pos;
  logic          run_a, run_b;
  int            delta;

  initial begin
    m_hist = {};
    m_filt = 2'b00;
    m_av = 1'b0; m_bv = 1'b0;
    m_primed = 1'b0; m_st = 2'b00;
    m_step = 1'b0; m_err = 1'b0;
    m_dir = 1'b1; m_pos = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_hist = {};
        m_filt = 2'b00;
        m_av = 1'b0; m_bv = 1'b0;
        m_primed = 1'b0; m_st = 2'b00;
        m_step = 1'b0; m_err = 1'b0;
        m_dir = 1'b1; m_pos = '0;
      end else begin
        m_step = 1'b0;
        m_err  = 1'b0;
        if (!m_primed) begin
          if (m_av && m_bv) begin
            m_primed = 1'b1;
            m_st = m_filt;
          end
        end else if (m_filt != m_st) begin
          delta = (gidx(m_filt) - gidx(m_st) + 4) % 4;
          if (delta == 1) begin
            m_step = 1'b1; m_dir = 1'b1;
            m_pos = m_pos + PW'(1);
          end else if (delta == 3) begin
            m_step = 1'b1; m_dir = 1'b0;
            m_pos = m_pos - PW'(1);
          end else begin
            m_err = 1'b1;
          end
          m_st = m_filt;
        end
        // a pin level counts once seen D times in a row, two clocks late
        m_hist.push_back({bus.enc_a, bus.enc_b});
        if (m_hist.size() > D + 2) void'(m_hist.pop_front());
        if (m_hist.size() == D + 2) begin
          run_a = 1'b1;
          run_b = 1'b1;
          for (int i = 1; i < D; i++) begin
            if (m_hist[i][1] != m_hist[0][1]) run_a = 1'b0;
            if (m_hist[i][0] != m_hist[0][0]) run_b = 1'b0;
          end
          if (run_a) begin m_filt[1] = m_hist[0][1]; m_av = 1'b1; end
          if (run_b) begin m_filt[0] = m_hist[0][0]; m_bv = 1'b1; end
        end
      end
    end
  end

  int            obs_steps = 0;
  int            obs_errs  = 0;
  int            obs_both  = 0;
  int            obs_diff  = 0;
  logic [PW-1:0] obs_last_pos = '0;

  initial forever begin
    @(posedge clk);
    #2;
    if (bus.step === 1'b1) begin
      obs_steps++;
      obs_last_pos = bus.position;
    end
    if (bus.err === 1'b1) obs_errs++;
    if (bus.step === 1'b1 && bus.err === 1'b1) obs_both++;
    if ({bus.step, bus.err, bus.dir, bus.position} !==
        {m_step, m_err, m_dir, m_pos}) begin
      obs_diff++;
      if (obs_diff <= 5)
        $display("  model diff @%0t: dut s=%b e=%b d=%b p=%h model s=%b e=%b d=%b p=%h",
                 $time, bus.step, bus.err, bus.dir, bus.position,
                 m_step, m_err, m_dir, m_pos);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold(input logic [1:0] ab, input int n);
    {bus.enc_a, bus.enc_b} = ab;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    {bus.enc_a, bus.enc_b} = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    int s0, e0, d0;
    {bus.enc_a, bus.enc_b} = 2'b00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.step, bus.err, bus.dir, bus.position} !==
        {1'b0, 1'b0, 1'b1, PW'(0)}) begin
      n_bad++;
      $display("FAIL reset_values: got s=%b e=%b d=%b p=%h want 0 0 1 0",
               bus.step, bus.err, bus.dir, bus.position);
    end
    rst = 1'b0;
    s0 = obs_steps; e0 = obs_errs; d0 = obs_diff;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (obs_steps - s0 !== 0 || obs_errs - e0 !== 0) begin
      n_bad++;
      $display("FAIL idle_pulses: got steps=%0d errs=%0d want 0 0",
               obs_steps - s0, obs_errs - e0);
    end
    n_cmp++;
    if (bus.position !== PW'(0) || bus.dir !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_hold: got p=%h d=%b want 0 1",
               bus.position, bus.dir);
    end
    n_cmp++;
    if (obs_diff !== d0) begin
      n_bad++;
      $display("FAIL reset_model: got %0d diff cycles want 0", obs_diff - d0);
    end
  endtask

  task automatic test_up_cycle();
    int s0, d0, lat;
    s0 = obs_steps; d0 = obs_diff; lat = -1;
    bus.enc_a = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (lat < 0 && bus.step === 1'b1) lat = i;
    end
    hold(2'b11, 20);
    hold(2'b01, 20);
    hold(2'b00, 20);
    n_cmp++;
    if (lat !== 7) begin
      n_bad++;
      $display("FAIL up_latency: got %0d cycles want 7", lat);
    end
    n_cmp++;
    if (obs_steps - s0 !== 4) begin
      n_bad++;
      $display("FAIL up_steps: got %0d want 4", obs_steps - s0);
    end
    n_cmp++;
    if (bus.position !== PW'(4) || bus.dir !== 1'b1) begin
      n_bad++;
      $display("FAIL up_pos: got p=%h d=%b want 4 1", bus.position, bus.dir);
    end
    n_cmp++;
    if (obs_diff !== d0) begin
      n_bad++;
      $display("FAIL up_model: got %0d diff cycles want 0", obs_diff - d0);
    end
  endtask

  task automatic test_down_wrap();
    int s0, d0;
    do_reset();
    d0 = obs_diff;
    hold(2'b10, 20);
    n_cmp++;
    if (bus.position !== PW'(1)) begin
      n_bad++;
      $display("FAIL down_start: got p=%h want 1", bus.position);
    end
    s0 = obs_steps;
    hold(2'b00, 20);
    hold(2'b01, 20);
    n_cmp++;
    if (obs_steps - s0 !== 2) begin
      n_bad++;
      $display("FAIL down_steps: got %0d want 2", obs_steps - s0);
    end
    n_cmp++;
    if (bus.position !== PW'(15) || bus.dir !== 1'b0) begin
      n_bad++;
      $display("FAIL down_wrap: got p=%h d=%b want f 0",
               bus.position, bus.dir);
    end
    n_cmp++;
    if (obs_diff !== d0) begin
      n_bad++;
      $display("FAIL down_model: got %0d diff cycles want 0", obs_diff - d0);
    end
  endtask

  task automatic test_full_wrap();
    int s0, d0;
    logic [1:0] up_seq [4];
    up_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    do_reset();
    s0 = obs_steps; d0 = obs_diff;
    for (int k = 0; k < 16; k++)
      hold(up_seq[k % 4], (k == 15) ? 20 : $urandom_range(D + 3, 3 * D + 4));
    n_cmp++;
    if (obs_steps - s0 !== 16) begin
      n_bad++;
      $display("FAIL wrap_steps: got %0d want 16", obs_steps - s0);
    end
    n_cmp++;
    if (obs_last_pos !== PW'(0) || bus.position !== PW'(0)) begin
      n_bad++;
      $display("FAIL wrap_pos: got last=%h now=%h want 0 0",
               obs_last_pos, bus.position);
    end
    n_cmp++;
    if (obs_diff !== d0) begin
      n_bad++;
      $display("FAIL wrap_model: got %0d diff cycles want 0", obs_diff - d0);
    end
  endtask

  task automatic test_glitch();
    int s0, e0, d0, g;
    logic [PW-1:0] p0;
    s0 = obs_steps; e0 = obs_errs; d0 = obs_diff;
    p0 = bus.position;
    hold(2'b10, 2);
    hold(2'b00, 20);
    for (int k = 0; k < 6; k++) begin
      g = $urandom_range(1, D - 1);
      hold(($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01, g);
      hold(2'b00, 20);
    end
    n_cmp++;
    if (obs_steps - s0 !== 0 || obs_errs - e0 !== 0) begin
      n_bad++;
      $display("FAIL glitch_pulses: got steps=%0d errs=%0d want 0 0",
               obs_steps - s0, obs_errs - e0);
    end
    n_cmp++;
    if (bus.position !== p0) begin
      n_bad++;
      $display("FAIL glitch_pos: got p=%h want %h", bus.position, p0);
    end
    n_cmp++;
    if (obs_diff !== d0) begin
      n_bad++;
      $display("FAIL glitch_model: got %0d diff cycles want 0", obs_diff - d0);
    end
  endtask

  task automatic test_illegal();
    int s0, e0;
    do_reset();
    hold(2'b10, 20);
    hold(2'b00, 20);
    s0 = obs_steps; e0 = obs_errs;
    hold(2'b11, 20);
    n_cmp++;
    if (obs_errs - e0 !== 1 || obs_steps - s0 !== 0) begin
      n_bad++;
      $display("FAIL illegal_pulse: got errs=%0d steps=%0d want 1 0",
               obs_errs - e0, obs_steps - s0);
    end
    n_cmp++;
    if (bus.position !== PW'(0) || bus.dir !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_hold: got p=%h d=%b want 0 0",
               bus.position, bus.dir);
    end
    s0 = obs_steps;
    hold(2'b01, 20);
    n_cmp++;
    if (obs_steps - s0 !== 1 || bus.dir !== 1'b1 ||
        bus.position !== PW'(1)) begin
      n_bad++;
      $display("FAIL illegal_after: got steps=%0d d=%b p=%h want 1 1 1",
               obs_steps - s0, bus.dir, bus.position);
    end
  endtask

  task automatic test_random();
    int d0, b0;
    do_reset();
    d0 = obs_diff; b0 = obs_both;
    for (int k = 0; k < 60; k++)
      hold(2'($urandom_range(0, 3)), $urandom_range(1, 3 * D + 4));
    hold({bus.enc_a, bus.enc_b}, 20);
    n_cmp++;
    if (obs_diff !== d0) begin
      n_bad++;
      $display("FAIL random_model: got %0d diff cycles want 0", obs_diff - d0);
    end
    n_cmp++;
    if (obs_both !== b0) begin
      n_bad++;
      $display("FAIL random_excl: got %0d step+err cycles want 0",
               obs_both - b0);
    end
  endtask

  task automatic test_reset_mid();
    int s0, e0, d0;
    logic [1:0] up_seq [4];
    up_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    do_reset();
    for (int k = 0; k < 5; k++) hold(up_seq[k % 4], 20);
    n_cmp++;
    if (bus.position !== PW'(5)) begin
      n_bad++;
      $display("FAIL mid_setup: got p=%h want 5", bus.position);
    end
    hold(2'b11, 3);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.step, bus.err, bus.dir, bus.position} !==
        {1'b0, 1'b0, 1'b1, PW'(0)}) begin
      n_bad++;
      $display("FAIL mid_reset: got s=%b e=%b d=%b p=%h want 0 0 1 0",
               bus.step, bus.err, bus.dir, bus.position);
    end
    rst = 1'b0;
    s0 = obs_steps; e0 = obs_errs; d0 = obs_diff;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (obs_steps - s0 !== 0 || obs_errs - e0 !== 0 ||
        bus.position !== PW'(0) || bus.dir !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reprime: got steps=%0d errs=%0d p=%h d=%b want 0 0 0 1",
               obs_steps - s0, obs_errs - e0, bus.position, bus.dir);
    end
    n_cmp++;
    if (obs_diff !== d0) begin
      n_bad++;
      $display("FAIL mid_model: got %0d diff cycles want 0", obs_diff - d0);
    end
  endtask

  initial begin
    {bus.enc_a, bus.enc_b} = 2'b00;
    @(negedge clk);
    test_reset();
    test_up_cycle();
    test_down_wrap();
    test_full_wrap();
    test_glitch();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
